issue_queue: RTL and testbench

// In-order instruction queue between decode and the dual-issue dispatcher.

---
 rtl/issue_queue.sv | 90 +++++++++
 tb/tb_issue_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_queue : dual-push / dual-pop in-order instruction queue feeding a dual-issue dispatcher
// Revision    : 1.0
// ----------------------------------------------------------------------------
module issue_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 127
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid0,
    input  logic                       in_valid1,
    input  logic [ENTRY_W-1:0]         in_entry0,
    input  logic [ENTRY_W-1:0]         in_entry1,
    output logic                       in_ready,
    output logic                       out_valid0,
    output logic                       out_valid1,
    output logic [ENTRY_W-1:0]         out_entry0,
    output logic [ENTRY_W-1:0]         out_entry1,
    input  logic [1:0]                 issue_cnt,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_storage [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_PTR_W-1:0] w_head1;
    logic [c_PTR_W-1:0] w_tail1;
    logic [c_CNT_W-1:0] w_free;
    logic [1:0]         w_issue;
    logic [1:0]         w_push_n;
    logic [1:0]         w_pop_n;

    assign w_head1 = r_head + c_PTR_W'(1);
    assign w_tail1 = r_tail + c_PTR_W'(1);
    assign w_free  = c_DEPTH_CNT - r_count;

    // Space check uses registered occupancy only; a same-cycle pop never frees room early.
    assign in_ready = (w_free >= c_CNT_W'(2));

    always_comb begin
        w_push_n = 2'd0;
        if (in_ready && in_valid0) begin
            w_push_n = in_valid1 ? 2'd2 : 2'd1;
        end
    end

    // Over-issue is clamped to what is actually held; code 3 behaves as 2.
    assign w_issue = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign w_pop_n = (r_count < c_CNT_W'(w_issue)) ? r_count[1:0] : w_issue;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_pop_n);
            r_tail  <= r_tail + c_PTR_W'(w_push_n);
            r_count <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (w_push_n != 2'd0) begin
                r_storage[r_tail] <= in_entry0;
            end
            if (w_push_n == 2'd2) begin
                r_storage[w_tail1] <= in_entry1;
            end
        end
    end

    assign count      = r_count;
    assign out_valid0 = (r_count >= c_CNT_W'(1));
    assign out_valid1 = (r_count >= c_CNT_W'(2));
    assign out_entry0 = out_valid0 ? r_storage[r_head]  : '0;
    assign out_entry1 = out_valid1 ? r_storage[w_head1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// tb_issue_queue : directed vector table, multi-cycle corner sequences and a
// reference-queue comparison for issue_queue.
module tb_issue_queue;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 127;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid0;
    logic               in_valid1;
    logic [ENTRY_W-1:0] in_entry0;
    logic [ENTRY_W-1:0] in_entry1;
    logic               in_ready;
    logic               out_valid0;
    logic               out_valid1;
    logic [ENTRY_W-1:0] out_entry0;
    logic [ENTRY_W-1:0] out_entry1;
    logic [1:0]         issue_cnt;
    logic [3:0]         count;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid0  (in_valid0),
        .in_valid1  (in_valid1),
        .in_entry0  (in_entry0),
        .in_entry1  (in_entry1),
        .in_ready   (in_ready),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_entry0 (out_entry0),
        .out_entry1 (out_entry1),
        .issue_cnt  (issue_cnt),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Spreads the pc across every field so each entry bit is exercised.
    function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_A5A5, ~pc, pc[4:0], pc[9:5], pc[14:10], pc[15:0]};
    endfunction

    function automatic logic [31:0] P(input int k);
        return 32'h1c00_0000 + 32'(4 * k);
    endfunction

    task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic v0, input logic v1,
                               input logic [ENTRY_W-1:0] e0, input logic [ENTRY_W-1:0] e1,
                               input logic rdy);
        chk({tag, ".count"},      ENTRY_W'(count),      ENTRY_W'(cnt));
        chk({tag, ".out_valid0"}, ENTRY_W'(out_valid0), ENTRY_W'(v0));
        chk({tag, ".out_valid1"}, ENTRY_W'(out_valid1), ENTRY_W'(v1));
        chk({tag, ".out_entry0"}, out_entry0,           e0);
        chk({tag, ".out_entry1"}, out_entry1,           e1);
        chk({tag, ".in_ready"},   ENTRY_W'(in_ready),   ENTRY_W'(rdy));
    endtask

    task automatic drive(input logic fl, input logic v0, input logic v1,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] iss);
        flush     = fl;
        in_valid0 = v0;
        in_valid1 = v1;
        in_entry0 = mk(p0);
        in_entry1 = mk(p1);
        issue_cnt = iss;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        v0;
        logic        v1;
        logic [31:0] pin0;
        logic [31:0] pin1;
        logic [1:0]  iss;
        int          cnt;
        logic        ov0;
        logic        ov1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
    } vec_t;

    function automatic vec_t V(input logic fl, input logic v0, input logic v1, input int k0, input int k1,
                               input logic [1:0] iss, input int cnt, input int e0, input int e1,
                               input logic rdy);
        vec_t t;
        t.fl = fl; t.v0 = v0; t.v1 = v1;
        t.pin0 = P(k0); t.pin1 = P(k1); t.iss = iss; t.cnt = cnt;
        t.ov0 = (cnt >= 1); t.ov1 = (cnt >= 2);
        t.pc0 = P(e0); t.pc1 = P(e1); t.rdy = rdy;
        return t;
    endfunction

    vec_t vecs [20];
    logic [ENTRY_W-1:0] mq [$];

    initial begin
        //           fl v0 v1 k0  k1  iss cnt e0  e1  rdy
        vecs[0]  = V(0, 1, 1,  0,  1, 0, 2,  0,  1, 1);  // first pair, program order
        vecs[1]  = V(0, 1, 0,  2,  3, 0, 3,  0,  1, 1);
        vecs[2]  = V(0, 0, 0,  0,  0, 1, 2,  1,  2, 1);  // single issue retires slot 0
        vecs[3]  = V(0, 0, 0,  0,  0, 2, 0,  0,  0, 1);
        vecs[4]  = V(0, 0, 1,  3,  4, 0, 0,  0,  0, 1);  // in_valid1 alone pushes nothing
        vecs[5]  = V(0, 1, 1,  5,  6, 0, 2,  5,  6, 1);
        vecs[6]  = V(0, 1, 1,  7,  8, 0, 4,  5,  6, 1);
        vecs[7]  = V(0, 1, 1,  9, 10, 0, 6,  5,  6, 1);
        vecs[8]  = V(0, 1, 1, 11, 12, 0, 8,  5,  6, 0);  // full
        vecs[9]  = V(0, 1, 1, 13, 14, 0, 8,  5,  6, 0);  // push on full ignored
        vecs[10] = V(0, 1, 1, 13, 14, 2, 6,  7,  8, 1);  // pop frees space next cycle only
        vecs[11] = V(0, 0, 0,  0,  0, 2, 4,  9, 10, 1);  // head=7, pair straddles wrap
        vecs[12] = V(0, 1, 1, 13, 14, 1, 5, 10, 11, 1);
        vecs[13] = V(1, 1, 1, 15, 16, 2, 0,  0,  0, 1);  // flush beats push and pop
        vecs[14] = V(0, 1, 1, 17, 18, 0, 2, 17, 18, 1);
        vecs[15] = V(0, 0, 0,  0,  0, 3, 0,  0,  0, 1);  // issue_cnt=3 acts as 2
        vecs[16] = V(0, 1, 0, 19,  0, 0, 1, 19,  0, 1);
        vecs[17] = V(0, 0, 0,  0,  0, 2, 0,  0,  0, 1);  // over-issue clamped
        vecs[18] = V(0, 1, 1, 20, 21, 1, 2, 20, 21, 1);  // pop on empty is nothing
        vecs[19] = V(0, 1, 1, 22, 23, 2, 2, 22, 23, 1);  // simultaneous push and pop

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check_state("reset", 0, 0, 0, '0, '0, 1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].fl, vecs[i].v0, vecs[i].v1, vecs[i].pin0, vecs[i].pin1, vecs[i].iss);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov0, vecs[i].ov1,
                        vecs[i].ov0 ? mk(vecs[i].pc0) : '0,
                        vecs[i].ov1 ? mk(vecs[i].pc1) : '0, vecs[i].rdy);
        end

        // Reset arriving mid-traffic with push and issue active.
        drive(0, 1, 1, P(24), P(25), 0);
        step();
        check_state("pre_rst", 4, 1, 1, mk(P(22)), mk(P(23)), 1);
        drive(0, 1, 1, P(26), P(27), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state("mid_rst", 0, 0, 0, '0, '0, 1);
        drive(0, 1, 0, P(28), 0, 0);
        step();
        check_state("post_rst", 1, 1, 0, mk(P(28)), '0, 1);
        drive(0, 0, 0, 0, 0, 2);
        step();
        check_state("drain", 0, 0, 0, '0, '0, 1);

        // Randomised traffic against a reference queue.
        mq.delete();
        for (int c = 0; c < 100; c++) begin
            logic        fl, v0, v1, rdy;
            logic [31:0] r0, r1;
            logic [1:0]  iss;
            int          sz;
            sz  = mq.size();
            fl  = ($urandom_range(0, 19) == 0);
            v0  = $urandom_range(0, 3) != 0;
            v1  = $urandom_range(0, 1) != 0;
            r0  = $urandom;
            r1  = $urandom;
            iss = 2'($urandom_range(0, (sz < 2) ? sz : 2));
            rdy = (DEPTH - sz >= 2);
            drive(fl, v0, v1, r0, r1, iss);
            step();
            if (fl) begin
                mq.delete();
            end else begin
                for (int k = 0; k < int'(iss); k++) void'(mq.pop_front());
                if (rdy && v0) begin
                    mq.push_back(mk(r0));
                    if (v1) mq.push_back(mk(r1));
                end
            end
            sz = mq.size();
            check_state($sformatf("rnd%0d", c), sz, sz >= 1, sz >= 2,
                        (sz >= 1) ? mq[0] : '0, (sz >= 2) ? mq[1] : '0, (DEPTH - sz >= 2));
        end

        drive(0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
